// File: rtl/alu_arb_seq.sv
// Round-robin arbiter for two requesters sharing one external add/sub unit.
// ADD/SUB/NEG take one pass through the unit; MUL is W shift-add passes.
module alu_arb_seq #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_res,
  output logic         rsp_cout,
  output logic         rsp_ovf,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_sub,
  input  logic [W-1:0] alu_res,
  input  logic         alu_cout,
  input  logic         alu_ovf
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StMul  = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpNeg = 2'b11;

  logic [1:0]      state_q, state_d;
  logic            rr_q, rr_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            id_q, id_d;
  logic [W-1:0]    res_q, res_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic gnt_any, gnt_id, idle;

  // Ties go to the rr pointer; a lone requester always wins.
  assign gnt_any    = req0_valid | req1_valid;
  assign gnt_id     = (req0_valid & req1_valid) ? rr_q : (req1_valid & ~req0_valid);
  assign idle       = (state_q == StIdle) & rst_n;
  assign req0_ready = idle & gnt_any & ~gnt_id;
  assign req1_ready = idle & gnt_any & gnt_id;

  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = id_q;
  assign rsp_res   = res_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sub = 1'b0;
    case (state_q)
      StExec: begin
        alu_a   = (op_q == OpNeg) ? '0 : a_q;
        alu_b   = b_q;
        alu_sub = (op_q != OpAdd);
      end
      StMul: begin
        alu_a = acc_q;
        alu_b = b_q[cnt_q] ? (a_q << cnt_q) : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (gnt_any) begin
          op_d    = gnt_id ? req1_op : req0_op;
          a_d     = gnt_id ? req1_a : req0_a;
          b_d     = gnt_id ? req1_b : req0_b;
          id_d    = gnt_id;
          rr_d    = ~gnt_id;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (op_d == OpMul) ? StMul : StExec;
        end
      end
      StExec: begin
        res_d   = alu_res;
        cout_d  = alu_cout;
        ovf_d   = alu_ovf;
        state_d = StResp;
      end
      StMul: begin
        acc_d = alu_res;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(W - 1)) begin
          res_d   = alu_res;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      op_q    <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_arb_seq.sv
// Directed bench for alu_arb_seq; the shared add/sub unit is modelled here.
module tb_alu_arb_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
  logic [W-1:0] rsp_res;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic         alu_sub, alu_cout, alu_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External unit: a + (sub ? ~b : b) + sub
  logic [W-1:0] eff_b;
  logic [W:0]   sum;
  assign eff_b    = alu_sub ? ~alu_b : alu_b;
  assign sum      = {1'b0, alu_a} + {1'b0, eff_b} + {{W{1'b0}}, alu_sub};
  assign alu_res  = sum[W-1:0];
  assign alu_cout = sum[W];
  assign alu_ovf  = (alu_a[W-1] == eff_b[W-1]) && (sum[W-1] != alu_a[W-1]);

  alu_arb_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_ovf(alu_ovf)
  );

  // Issues one op and returns at the first cycle rsp_valid is seen.
  task automatic send(input logic id, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, output int lat, output logic [W-1:0] res,
                      output logic cout, output logic ovf, output logic rid);
    int n = 0;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_ready_timeout: ready never rose for id %0d", id);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    res = rsp_res; cout = rsp_cout; ovf = rsp_ovf; rid = rsp_id;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = 2'b00; req1_op = 2'b00;
    req0_a = 4'h1; req0_b = 4'h1; req1_a = 4'h2; req1_b = 4'h2;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_res, rsp_cout, rsp_ovf} !== 8'h00) begin
      errors++; $display("FAIL reset_rsp: got %b want 0",
                         {rsp_valid, rsp_id, rsp_res, rsp_cout, rsp_ovf});
    end
    checks++;
    if ({alu_a, alu_b, alu_sub} !== 9'h000) begin
      errors++; $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_sub});
    end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat; logic [W-1:0] res; logic c, o, rid;
    send(1'b0, 2'b00, 4'd3, 4'd4, lat, res, c, o, rid);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
    checks++;
    if ({res, c, o, rid} !== {4'h7, 3'b000}) begin
      errors++; $display("FAIL add_3_4: got res %h c %b o %b id %b want 7 0 0 0", res, c, o, rid);
    end
  endtask

  task automatic test_sub_ovf();
    int lat; logic [W-1:0] res; logic c, o, rid;
    send(1'b1, 2'b01, 4'd2, 4'd5, lat, res, c, o, rid);
    checks++;
    if ({res, c, o, rid} !== {4'hD, 3'b001}) begin
      errors++; $display("FAIL sub_2_5: got res %h c %b o %b id %b want d 0 0 1", res, c, o, rid);
    end
    send(1'b0, 2'b00, 4'd7, 4'd1, lat, res, c, o, rid);
    checks++;
    if ({res, c, o, rid} !== {4'h8, 3'b010}) begin
      errors++; $display("FAIL add_ovf: got res %h c %b o %b id %b want 8 0 1 0", res, c, o, rid);
    end
  endtask

  task automatic test_mul_neg();
    int lat; logic [W-1:0] res; logic c, o, rid;
    send(1'b0, 2'b10, 4'd3, 4'd5, lat, res, c, o, rid);
    checks++;
    if (lat !== W + 1) begin errors++; $display("FAIL mul_latency: got %0d want %0d", lat, W + 1); end
    checks++;
    if ({res, c, o} !== {4'hF, 2'b00}) begin
      errors++; $display("FAIL mul_3_5: got res %h c %b o %b want f 0 0", res, c, o);
    end
    send(1'b1, 2'b10, 4'hF, 4'd3, lat, res, c, o, rid);
    checks++;
    if ({res, c, o, rid} !== {4'hD, 3'b001}) begin
      errors++; $display("FAIL mul_f_3: got res %h c %b o %b id %b want d 0 0 1", res, c, o, rid);
    end
    send(1'b0, 2'b11, 4'h5, 4'h8, lat, res, c, o, rid);
    checks++;
    if ({res, o} !== {4'h8, 1'b1}) begin
      errors++; $display("FAIL neg_8: got res %h o %b want 8 1", res, o);
    end
    send(1'b0, 2'b11, 4'h5, 4'h0, lat, res, c, o, rid);
    checks++;
    if ({res, c, o} !== {4'h0, 2'b10}) begin
      errors++; $display("FAIL neg_0: got res %h c %b o %b want 0 1 0", res, c, o);
    end
  endtask

  task automatic test_round_robin();
    logic gnt[4]; logic ids[4]; logic [W-1:0] rr_res[4];
    int g = 0; int r = 0; int n = 0;
    @(posedge clk); #1;
    apply_reset();
    rsp_ready = 1'b1;
    req0_op = 2'b00; req0_a = 4'd1; req0_b = 4'd1;
    req1_op = 2'b00; req1_a = 4'd2; req1_b = 4'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    while (r < 4 && n < 60) begin
      if (req0_ready && req1_ready) begin
        checks++; errors++;
        $display("FAIL rr_both_ready: got 11 want one-hot");
      end
      if ((req0_ready || req1_ready) && g < 4) begin gnt[g] = req1_ready; g++; end
      if (rsp_valid) begin ids[r] = rsp_id; rr_res[r] = rsp_res; r++; end
      @(posedge clk); #1; n++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (g != 4 || r != 4) begin
      errors++; $display("FAIL rr_count: got %0d grants %0d rsps want 4 4", g, r);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gnt[k] !== k[0] || ids[k] !== k[0]) begin
          errors++; $display("FAIL rr_order_%0d: got grant %b id %b want %b", k, gnt[k], ids[k], k[0]);
        end
        checks++;
        if (rr_res[k] !== (k[0] ? 4'd4 : 4'd2)) begin
          errors++; $display("FAIL rr_res_%0d: got %h want %h", k, rr_res[k], k[0] ? 4'd4 : 4'd2);
        end
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int lat; logic [W-1:0] res; logic c, o, rid;
    rsp_ready = 1'b0;
    send(1'b1, 2'b00, 4'd5, 4'd6, lat, res, c, o, rid);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = 2'b00; req1_op = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_res, rsp_cout, rsp_ovf, rsp_id, req0_ready, req1_ready}
          !== {1'b1, 4'hB, 1'b0, 1'b1, 1'b1, 2'b00}) begin
        errors++; $display("FAIL hold_%0d: got v %b res %h c %b o %b id %b rdy %b%b want 1 b 0 1 1 00",
                           k, rsp_valid, rsp_res, rsp_cout, rsp_ovf, rsp_id, req0_ready, req1_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin
      errors++; $display("FAIL release_idle: got v %b rdy %b%b want 0 10",
                         rsp_valid, req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mul();
    int n = 0;
    req0_op = 2'b10; req0_a = 4'd3; req0_b = 4'd5; req0_valid = 1'b1;
    #1;
    while (!req0_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (alu_b !== 4'hC) begin errors++; $display("FAIL mul_step2_b: got %h want c", alu_b); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({rsp_valid, alu_a, alu_b, alu_sub, rsp_res} !== 14'h0) begin
      errors++; $display("FAIL abort_state: got v %b a %h b %h s %b res %h want all 0",
                         rsp_valid, alu_a, alu_b, alu_sub, rsp_res);
    end
    req0_op = 2'b00; req1_op = 2'b00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL abort_rr: got %b%b want 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_ovf();
    test_mul_neg();
    test_round_robin();
    test_backpressure();
    test_reset_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
